// File: rtl/regfile_32x32_wb_if.sv
// Bus bundle for regfile_32x32_wb.
// Groups the write request, the two read ports and the committed-array
// tap. The slave modport is the register file. The master modport is the
// core or bench driving it.
//   write_en/write_addr/write_data : write request, sampled on rising clk
//   read_addr1/read_addr2          : read port indices
//   read_data1/read_data2          : combinational read results
//   regs                           : committed array, row i = register i
interface regfile_32x32_wb_if;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] regs [32];

  modport slave (
    input  write_en, write_addr, write_data, read_addr1, read_addr2,
    output read_data1, read_data2, regs
  );

  modport master (
    output write_en, write_addr, write_data, read_addr1, read_addr2,
    input  read_data1, read_data2, regs
  );
endinterface

// File: rtl/regfile_32x32_wb.sv
// 32 x 32-bit register file with a one-entry write-back stage.
// A write sampled at edge N is held in the pending stage. It is written
// into the array at edge N+1. Register 0 always reads as zero and is never
// written.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset, clears array and pending stage
//   bus   : regfile_32x32_wb_if.slave (write request, two read ports, regs)
// BYPASS_EN=1 : reads forward the pending write when the address matches.
// BYPASS_EN=0 : reads see only committed contents.
module regfile_32x32_wb #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_32x32_wb_if.slave    bus
);

  logic [31:0] arr [32];
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic [31:0] pend_data;

  // Read selection, shared by both ports. The word is passed in so the
  // function stays pure.
  function automatic logic [31:0] rd_sel(
    input logic [4:0]  a,
    input logic [31:0] word,
    input logic        pv,
    input logic [4:0]  pa,
    input logic [31:0] pd
  );
    if (a == 5'd0)
      return 32'h0;
    else if (BYPASS_EN && pv && (pa == a))
      return pd;
    else
      return word;
  endfunction

  // Capture into the pending stage and commit the previous entry on the
  // same edge. Reset wins, so an entry pending at the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) arr[i] <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      if (pend_valid) arr[pend_addr] <= pend_data;
      // Writes to register 0 are discarded outright.
      pend_valid <= bus.write_en && (bus.write_addr != 5'd0);
      if (bus.write_en && (bus.write_addr != 5'd0)) begin
        pend_addr <= bus.write_addr;
        pend_data <= bus.write_data;
      end
    end
  end

  always_comb begin
    bus.read_data1 = rd_sel(bus.read_addr1, arr[bus.read_addr1],
                            pend_valid, pend_addr, pend_data);
    bus.read_data2 = rd_sel(bus.read_addr2, arr[bus.read_addr2],
                            pend_valid, pend_addr, pend_data);
  end

  // The regs tap exposes committed contents only. Row 0 is tied to zero.
  always_comb begin
    for (int i = 0; i < 32; i++) bus.regs[i] = (i == 0) ? 32'h0 : arr[i];
  end

endmodule

// File: tb/tb_regfile_32x32_wb.sv
module tb_regfile_32x32_wb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_32x32_wb_if bif_b ();
  regfile_32x32_wb_if bif_n ();

  regfile_32x32_wb #(.BYPASS_EN(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(bif_b.slave));
  regfile_32x32_wb #(.BYPASS_EN(1'b0)) u_n (.clk(clk), .rst_n(rst_n), .bus(bif_n.slave));

  int total = 0;
  int bad   = 0;

  // Reference model. The committed image and the writes still in flight.
  // A write becomes part of the committed image one edge after it is accepted.
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  logic [31:0] m_mem [32];
  wr_t         inflight [$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1, r2;
    logic [31:0] e1b, e2b, e1n, e2n;
    logic [4:0]  ra;
    logic [31:0] er;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = m_mem[a];
    if (byp) foreach (inflight[k]) if (inflight[k].a == a) v = inflight[k].d;
    return v;
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bif_b.write_en = we; bif_b.write_addr = wa; bif_b.write_data = wd;
    bif_b.read_addr1 = r1; bif_b.read_addr2 = r2;
    bif_n.write_en = we; bif_n.write_addr = wa; bif_n.write_data = wd;
    bif_n.read_addr1 = r1; bif_n.read_addr2 = r2;
  endtask

  // Apply inputs for one edge, advance the model, then settle for checking.
  task automatic step(input logic rn, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    drive(we, wa, wd, r1, r2);
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      inflight.delete();
    end else begin
      while (inflight.size() > 0) begin
        m_mem[inflight[0].a] = inflight[0].d;
        void'(inflight.pop_front());
      end
      if (we && wa != 0) inflight.push_back('{a: wa, d: wd});
    end
    #1;
  endtask

  task automatic check_regs(input string name);
    int diff_b, diff_n;
    diff_b = -1; diff_n = -1;
    for (int i = 31; i >= 0; i--) begin
      if (bif_b.regs[i] !== m_mem[i]) diff_b = i;
      if (bif_n.regs[i] !== m_mem[i]) diff_n = i;
    end
    total += 2;
    if (diff_b >= 0) begin
      bad++;
      $display("FAIL %s regs(byp) row %0d: got %h expected %h", name, diff_b, bif_b.regs[diff_b], m_mem[diff_b]);
    end
    if (diff_n >= 0) begin
      bad++;
      $display("FAIL %s regs(nobyp) row %0d: got %h expected %h", name, diff_n, bif_n.regs[diff_n], m_mem[diff_n]);
    end
  endtask

  task automatic check_reads(input string name);
    check({name, " rd1 byp"},   bif_b.read_data1, m_rd(bif_b.read_addr1, 1'b1));
    check({name, " rd2 byp"},   bif_b.read_data2, m_rd(bif_b.read_addr2, 1'b1));
    check({name, " rd1 nobyp"}, bif_n.read_data1, m_rd(bif_n.read_addr1, 1'b0));
    check({name, " rd2 nobyp"}, bif_n.read_data2, m_rd(bif_n.read_addr2, 1'b0));
  endtask

  initial begin
    tbl[0] = '{we:1, wa:5,  wd:32'hDEADBEEF, r1:5,  r2:0,  e1b:32'hDEADBEEF, e2b:0, e1n:0, e2n:0, ra:5, er:0};
    tbl[1] = '{we:0, wa:0,  wd:0, r1:5,  r2:5,  e1b:32'hDEADBEEF, e2b:32'hDEADBEEF, e1n:32'hDEADBEEF, e2n:32'hDEADBEEF, ra:5, er:32'hDEADBEEF};
    tbl[2] = '{we:1, wa:0,  wd:32'hFFFFFFFF, r1:0, r2:0, e1b:0, e2b:0, e1n:0, e2n:0, ra:0, er:0};
    tbl[3] = '{we:1, wa:7,  wd:1, r1:7, r2:7, e1b:1, e2b:1, e1n:0, e2n:0, ra:7, er:0};
    tbl[4] = '{we:1, wa:7,  wd:2, r1:7, r2:7, e1b:2, e2b:2, e1n:1, e2n:1, ra:7, er:1};
    tbl[5] = '{we:0, wa:0,  wd:0, r1:7, r2:5, e1b:2, e2b:32'hDEADBEEF, e1n:2, e2n:32'hDEADBEEF, ra:7, er:2};
    tbl[6] = '{we:1, wa:12, wd:32'h1234, r1:12, r2:12, e1b:32'h1234, e2b:32'h1234, e1n:0, e2n:0, ra:12, er:0};
    tbl[7] = '{we:1, wa:12, wd:32'h5678, r1:12, r2:12, e1b:32'h5678, e2b:32'h5678, e1n:32'h1234, e2n:32'h1234, ra:12, er:32'h1234};
    tbl[8] = '{we:0, wa:0,  wd:0, r1:12, r2:12, e1b:32'h5678, e2b:32'h5678, e1n:32'h5678, e2n:32'h5678, ra:12, er:32'h5678};

    foreach (m_mem[i]) m_mem[i] = 32'h0;
    drive(0, 0, 0, 0, 0);

    // Reset: every address reads zero and regs are all zero.
    step(0, 1, 4, 32'h11111111, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 32; a += 5) begin
      drive(0, 0, 0, a[4:0], a[4:0]);
      #1;
      check("reset rd1 byp",   bif_b.read_data1, 32'h0);
      check("reset rd2 nobyp", bif_n.read_data2, 32'h0);
    end
    check_regs("reset");

    // Directed vectors: bypass, commit latency, addr 0, same-address hazards.
    for (int i = 0; i < 9; i++) begin
      step(1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2);
      check($sformatf("vec%0d rd1 byp", i),   bif_b.read_data1, tbl[i].e1b);
      check($sformatf("vec%0d rd2 byp", i),   bif_b.read_data2, tbl[i].e2b);
      check($sformatf("vec%0d rd1 nobyp", i), bif_n.read_data1, tbl[i].e1n);
      check($sformatf("vec%0d rd2 nobyp", i), bif_n.read_data2, tbl[i].e2n);
      check($sformatf("vec%0d regs byp", i),   bif_b.regs[tbl[i].ra], tbl[i].er);
      check($sformatf("vec%0d regs nobyp", i), bif_n.regs[tbl[i].ra], tbl[i].er);
      if (i == 2) check("addr0 write pend_valid", {31'h0, u_b.pend_valid}, 32'h0);
    end

    // Fill all writable registers with their index, then reset while a
    // write to register 3 is pending.
    for (int a = 1; a < 32; a++) step(1, 1, a[4:0], a, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("fill regs[17]", bif_b.regs[17], 32'd17);
    check("fill regs[31]", bif_n.regs[31], 32'd31);
    step(1, 1, 3, 32'hA5A5A5A5, 3, 3);
    check("pending A5 bypass", bif_b.read_data1, 32'hA5A5A5A5);
    check("pending A5 nobyp",  bif_n.read_data1, 32'd3);
    step(0, 0, 0, 0, 3, 3);
    check("reset drops pending rd1 byp", bif_b.read_data1, 32'h0);
    check("reset drops pending regs[3]", bif_b.regs[3], 32'h0);
    check_regs("after mid reset");
    step(1, 0, 0, 0, 3, 3);
    check("A5 never committed", bif_n.regs[3], 32'h0);
    for (int a = 1; a < 32; a += 3) begin
      drive(0, 0, 0, a[4:0], a[4:0]);
      #1;
      check("post reset rd1", bif_b.read_data1, 32'h0);
      check("post reset rd2", bif_n.read_data2, 32'h0);
    end

    // First edge with reset released accepts a write.
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 32'h99, 9, 9);
    check("first edge after reset capture", bif_b.read_data1, 32'h99);
    step(1, 0, 0, 0, 9, 9);
    check("first edge after reset commit", bif_b.regs[9], 32'h99);

    // Randomised traffic against the model. Addresses are biased low to
    // provoke same-address hazards, with occasional resets.
    for (int n = 0; n < 500; n++) begin
      logic rn, we;
      logic [4:0] wa, r1, r2;
      rn = ($urandom_range(0, 59) != 0);
      we = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom);
      step(rn, we, wa, $urandom, r1, r2);
      check_reads("rand");
      check_regs("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
